// File: rtl/dict_decomp_fetch.sv
// Dictionary-based instruction decompressor. A byte PC selects a token in the
// compressed ROM; the token indexes a writable dictionary that holds full instructions.
module dict_decomp_fetch #(
  parameter int    INSTR_W    = 32,
  parameter int    PC_W       = 32,
  parameter int    PC_BASE    = 0,
  parameter int    TOKEN_W    = 4,
  parameter int    CWORD_W    = 32,
  parameter int    CROM_DEPTH = 77,
  parameter string DICT_FILE  = "",
  parameter string CROM_FILE  = "",
  parameter int    BUF_EN     = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [PC_W-1:0]    req_pc,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [INSTR_W-1:0] rsp_instr,
  output logic               rsp_err,
  input  logic               dict_we,
  input  logic [TOKEN_W-1:0] dict_waddr,
  input  logic [INSTR_W-1:0] dict_wdata,
  input  logic               buf_flush
);
  localparam int PACK   = CWORD_W / TOKEN_W;
  localparam int DICT_D = 1 << TOKEN_W;
  localparam int SLOT_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int WORD_W = (CROM_DEPTH > 1) ? $clog2(CROM_DEPTH) : 1;
  localparam logic [PC_W-1:0] BASE    = PC_W'(PC_BASE);
  localparam logic [PC_W-1:0] PACK_PC = PC_W'(PACK);
  localparam logic [PC_W-1:0] DEPTH_PC = PC_W'(CROM_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_LOOKUP = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [CWORD_W-1:0] crom_mem [CROM_DEPTH];
  logic [INSTR_W-1:0] dict_mem [DICT_D];

  always_ff @(posedge clk) begin
    if (dict_we) dict_mem[dict_waddr] <= dict_wdata;
  end

  logic [1:0]         state_q, state_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic               buf_vld_q, buf_vld_d;
  logic [WORD_W-1:0]  buf_tag_q, buf_tag_d;
  logic [CWORD_W-1:0] buf_data_q, buf_data_d;
  logic [INSTR_W-1:0] rsp_instr_q, rsp_instr_d;
  logic               rsp_err_q, rsp_err_d;

  logic [PC_W-1:0] pc_off, pc_idx, pc_word;
  logic            pc_err, buf_hit;
  logic [PACK-1:0][TOKEN_W-1:0] buf_slots;
  logic [TOKEN_W-1:0] token;

  always_comb begin
    pc_off  = req_pc - BASE;
    pc_idx  = pc_off >> 2;
    pc_word = pc_idx / PACK_PC;
    pc_err  = (req_pc[1:0] != 2'b00) || (req_pc < BASE) || (pc_word >= DEPTH_PC);
    buf_hit = (BUF_EN != 0) && buf_vld_q && (buf_tag_q == WORD_W'(pc_word));
  end

  assign buf_slots = buf_data_q[PACK*TOKEN_W-1:0];
  assign token     = buf_slots[slot_q];

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    slot_d      = slot_q;
    buf_vld_d   = buf_vld_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    rsp_instr_d = rsp_instr_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        word_d = WORD_W'(pc_word);
        slot_d = SLOT_W'(pc_idx % PACK_PC);
        if (pc_err) begin
          rsp_err_d   = 1'b1;
          rsp_instr_d = '0;
          state_d     = S_RESP;
        end else begin
          rsp_err_d = 1'b0;
          state_d   = buf_hit ? S_LOOKUP : S_FETCH;
        end
      end
      S_FETCH: begin
        buf_data_d = crom_mem[word_q];
        buf_tag_d  = word_q;
        buf_vld_d  = (BUF_EN != 0);
        state_d    = S_LOOKUP;
      end
      S_LOOKUP: begin
        // write-first: a same-cycle dictionary write is what the consumer sees
        rsp_instr_d = (dict_we && dict_waddr == token) ? dict_wdata : dict_mem[token];
        rsp_err_d   = 1'b0;
        state_d     = S_RESP;
      end
      default: if (rsp_ready) state_d = S_IDLE;
    endcase
    // a flush on the FETCH edge leaves the line invalid even though it was just loaded
    if (buf_flush) buf_vld_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      word_q      <= '0;
      slot_q      <= '0;
      buf_vld_q   <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
      rsp_instr_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      slot_q      <= slot_d;
      buf_vld_q   <= buf_vld_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_instr = rsp_instr_q;
  assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dict_decomp_fetch.sv
// Scoreboard bench for dict_decomp_fetch: a PC/ROM/dictionary model pushes the
// expected instruction, error flag and latency; responses are popped and compared.
module tb_dict_decomp_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_pc, rsp_instr, dict_wdata;
  logic        dict_we, buf_flush;
  logic [3:0]  dict_waddr;

  dict_decomp_fetch dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr), .rsp_err(rsp_err),
    .dict_we(dict_we), .dict_waddr(dict_waddr), .dict_wdata(dict_wdata),
    .buf_flush(buf_flush)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
    logic [7:0]  lat;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] crom_m [77];
  logic [31:0] dict_m [16];
  bit          mvld;
  int          mtag;
  int          n_tests, n_fail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_push(input logic [31:0] pc);
    exp_t        e;
    logic [31:0] n, w, cw;
    int          slot;
    n = pc >> 2;
    w = n / 8;
    slot = int'(n % 8);
    if (pc[1:0] != 2'b00 || w >= 77) begin
      e.instr = '0; e.err = 1'b1; e.lat = 8'd1;
    end else begin
      cw = crom_m[w];
      e.instr = dict_m[cw[slot*4 +: 4]];
      e.err = 1'b0;
      e.lat = (mvld && mtag == int'(w)) ? 8'd2 : 8'd3;
      mvld = 1'b1;
      mtag = int'(w);
    end
    sb_q.push_back(e);
  endtask

  // wr: dictionary write to index 3 during LOOKUP; ffl: flush during FETCH;
  // stall: cycles rsp_ready stays low once the response is up
  task automatic do_req(input logic [31:0] pc, input bit wr, input bit ffl, input int stall);
    exp_t e;
    int   lat;
    @(negedge clk);
    chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
    rsp_ready = (stall == 0);
    req_valid = 1'b1;
    req_pc    = pc;
    if (wr) dict_m[3] = 32'hE1A0_0000;
    model_push(pc);
    if (ffl) mvld = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      buf_flush  = ffl && lat == 1;
      dict_we    = wr && lat == 2;
      dict_waddr = 4'd3;
      dict_wdata = 32'hE1A0_0000;
      @(negedge clk);
      buf_flush = 1'b0;
      dict_we   = 1'b0;
      lat++;
    end
    e = sb_q.pop_front();
    chk($sformatf("lat@%0h", pc), 64'(lat), 64'(e.lat));
    chk($sformatf("instr@%0h", pc), 64'(rsp_instr), 64'(e.instr));
    chk($sformatf("err@%0h", pc), 64'(rsp_err), 64'(e.err));
    if (stall > 0) begin
      req_valid = 1'b1;
      req_pc    = 32'h0000_0004;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk("stall_valid", 64'(rsp_valid), 64'd1);
        chk("stall_instr", 64'(rsp_instr), 64'(e.instr));
        chk("stall_req_ready", 64'(req_ready), 64'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    chk("rsp_drop", 64'(rsp_valid), 64'd0);
  endtask

  task automatic flush_idle();
    @(negedge clk);
    buf_flush = 1'b1;
    @(negedge clk);
    buf_flush = 1'b0;
    mvld = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; mvld = 1'b0; mtag = 0;
    reset = 1'b0; req_valid = 1'b0; req_pc = '0; rsp_ready = 1'b1;
    dict_we = 1'b0; dict_waddr = '0; dict_wdata = '0; buf_flush = 1'b0;
    for (int i = 0; i < 77; i++) crom_m[i] = $urandom;
    crom_m[1][11:8] = 4'd3;
    for (int i = 0; i < 77; i++) dut.crom_mem[i] = crom_m[i];
    #12;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_instr", 64'(rsp_instr), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      dict_m[i]  = $urandom;
      dict_we    = 1'b1;
      dict_waddr = 4'(i);
      dict_wdata = dict_m[i];
    end
    @(negedge clk);
    dict_we = 1'b0;

    for (int i = 0; i < 8; i++) do_req(32'(i * 4), 1'b0, 1'b0, 0);
    do_req(32'h0000_0002, 1'b0, 1'b0, 0);
    do_req(32'h0000_09A0, 1'b0, 1'b0, 0);
    do_req(32'h0000_0998, 1'b0, 1'b0, 0);
    do_req(32'hFFFF_FFFC, 1'b0, 1'b0, 0);
    do_req(32'h0000_0010, 1'b0, 1'b0, 5);
    do_req(32'h0000_0028, 1'b1, 1'b0, 0);
    do_req(32'h0000_002C, 1'b0, 1'b0, 0);
    do_req(32'h0000_0000, 1'b0, 1'b0, 0);
    flush_idle();
    do_req(32'h0000_0004, 1'b0, 1'b0, 0);
    do_req(32'h0000_0040, 1'b0, 1'b1, 0);
    do_req(32'h0000_0044, 1'b0, 1'b0, 0);

    // abort a miss in its FETCH cycle
    @(negedge clk);
    req_valid = 1'b1;
    req_pc    = 32'h0000_0080;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("abort_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    mvld = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_rsp", 64'(rsp_valid), 64'd0);
    end
    do_req(32'h0000_0080, 1'b0, 1'b0, 0);

    for (int i = 0; i < 12; i++) begin
      logic [31:0] pc;
      pc = 32'($urandom_range(0, 640)) << 2;
      if (i % 4 == 3) pc = pc | 32'd1;
      do_req(pc, 1'b0, 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
